tia_line_scheduler: RTL and testbench
=====================================

TIA_LINE_SCHEDULER -- requirements
Module: tia_line_scheduler

Interface
REQ-001 SHALL have no parameters; line length 228 color clocks, HBLANK 68, HMOVE-extended HBLANK 76, HSYNC window 16..31 are fixed constants.
REQ-002 SHALL provide ports:
  clk  in  1  color clock; single clock, all state updates on rising edge
  resphi0  in  1  reset, synchronous, active-high
  wsync  in  1  CPU write strobe to WSYNC, one clk wide
  rsyn  in  1  CPU write strobe to RSYNC, one clk wide
  hmove  in  1  CPU write strobe to HMOVE, one clk wide
  phi_theta  out  1  CPU-phase pulse, high one clk in every three
  rdy  out  1  CPU ready; 0 = CPU halted by WSYNC
  hcount  out  8  horizontal color-clock position, 0..227
  line_start  out  1  high while hcount==0
  hsync  out  1  horizontal sync
  hblank  out  1  horizontal blank
REQ-003 SHALL drive every output to a defined 0/1 at all times after the first reset edge, never x or z.

Function
REQ-004 SHALL hold a 2-bit phase counter p cycling 0->1->2->0 each clk; phi_theta = (p==2), decoded from registered state.
REQ-005 SHALL hold hcount: increment each clk, 227->0 wrap (line wrap), values 228..255 unreachable.
REQ-006 SHALL decode line_start = (hcount==0); hsync = (16 <= hcount <= 31).
REQ-007 SHALL decode hblank = (hcount < 68) or (hmove_line and hcount < 76).
REQ-008 wsync SHALL be accepted only on a clk where phi_theta==1; ignored otherwise.
REQ-009 Accepted wsync SHALL drive rdy to 0 from the next clk, held until the line wrap.
REQ-010 rdy SHALL return to 1 on the same edge hcount becomes 0 (wrap or accepted rsyn); release has priority over a simultaneous accepted wsync.
REQ-011 Result of REQ-010: wsync accepted at hcount==227 leaves rdy at 1.
REQ-012 wsync while rdy==0 SHALL have no effect.
REQ-013 rsyn SHALL be accepted only on a clk where phi_theta==0; rsyn while phi_theta==1 is dropped, not deferred.
REQ-014 Accepted rsyn SHALL load hcount=0 on the next edge and count as a line wrap for REQ-010 and REQ-016; p is unaffected.
REQ-015 hmove SHALL be accepted only when phi_theta==1; it sets flag hmove_pending.
REQ-016 On each line wrap, hmove_line SHALL take hmove_pending, and hmove_pending SHALL clear; a simultaneous accepted hmove sets hmove_pending for the following line.
REQ-017 SHALL never combinationally pass any strobe input to an output.

Reset
REQ-018 On a clk edge with resphi0==1: p=0, hcount=0, rdy=1, hmove_pending=0, hmove_line=0; all strobes ignored that cycle.
REQ-019 Outputs after reset: phi_theta=0, line_start=1, hsync=0, hblank=1, rdy=1, hcount=0.
REQ-020 Reset asserted mid-halt SHALL release rdy on the next edge; mid-line it SHALL restart the line at 0.

Verification
REQ-021 Reset, then free-run 456 clks -> phi_theta high at clks 2,5,8,... (152 pulses); hcount wraps at clks 228 and 456; hsync high clks 16..31; hblank high clks 0..67.
REQ-022 wsync pulse at hcount 50 with phi_theta=1 -> rdy 0 from hcount 51 through 227, rdy 1 at hcount 0; same pulse at hcount 51 (phi_theta=0) -> rdy stays 1.
REQ-023 wsync at hcount 227 (phi_theta=1) -> rdy never drops; wsync repeated at hcount 100 while halted -> no change.
REQ-024 rsyn at hcount 100 (phi_theta=0) while rdy=0 -> next hcount 0, rdy 1, line_start 1; rsyn at hcount 101 (phi_theta=1) -> ignored, hcount 102.
REQ-025 hmove at hcount 80 (phi_theta=1) -> current line hblank ends at 67; next line hblank high hcount 0..75; line after that 0..67.
REQ-026 resphi0 pulse at hcount 150 during WSYNC halt -> next edge hcount 0, rdy 1, phi_theta 0, then cadence restarts as REQ-021.

Source files
------------

// File: rtl/tia_line_scheduler.sv
// ============================================================================
// Module      : tia_line_scheduler
// Description : TIA horizontal timing: CPU phase, color-clock counter,
//               sync/blank decode, WSYNC halt, RSYNC restart and HMOVE blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tia_line_scheduler (
    input  logic       clk,
    input  logic       resphi0,
    input  logic       wsync,
    input  logic       rsyn,
    input  logic       hmove,
    output logic       phi_theta,
    output logic       rdy,
    output logic [7:0] hcount,
    output logic       line_start,
    output logic       hsync,
    output logic       hblank
);

    localparam logic [7:0] c_line_last     = 8'd227;
    localparam logic [7:0] c_hblank_end    = 8'd68;
    localparam logic [7:0] c_hblank_ext    = 8'd76;
    localparam logic [7:0] c_hsync_first   = 8'd16;
    localparam logic [7:0] c_hsync_last    = 8'd31;
    localparam logic [1:0] c_phase_last    = 2'd2;

    logic [1:0] r_p;
    logic [7:0] r_hcount;
    logic       r_rdy;
    logic       r_hmove_pending;
    logic       r_hmove_line;

    logic w_phi;
    logic w_wsync_acc;
    logic w_rsyn_acc;
    logic w_hmove_acc;
    logic w_wrap;

    assign w_phi       = (r_p == c_phase_last);
    assign w_wsync_acc = wsync & w_phi;
    assign w_rsyn_acc  = rsyn & ~w_phi;
    assign w_hmove_acc = hmove & w_phi;
    // An accepted RSYNC is treated exactly like the natural end of line.
    assign w_wrap      = (r_hcount == c_line_last) | w_rsyn_acc;

    always_ff @(posedge clk) begin
        if (resphi0) begin
            r_p             <= 2'd0;
            r_hcount        <= 8'd0;
            r_rdy           <= 1'b1;
            r_hmove_pending <= 1'b0;
            r_hmove_line    <= 1'b0;
        end else begin
            r_p <= w_phi ? 2'd0 : r_p + 2'd1;

            if (w_wrap) begin
                r_hcount        <= 8'd0;
                r_rdy           <= 1'b1;
                r_hmove_line    <= r_hmove_pending;
                r_hmove_pending <= w_hmove_acc;
            end else begin
                r_hcount <= r_hcount + 8'd1;
                if (w_wsync_acc) begin
                    r_rdy <= 1'b0;
                end
                if (w_hmove_acc) begin
                    r_hmove_pending <= 1'b1;
                end
            end
        end
    end

    assign phi_theta  = w_phi;
    assign rdy        = r_rdy;
    assign hcount     = r_hcount;
    assign line_start = (r_hcount == 8'd0);
    assign hsync      = (r_hcount >= c_hsync_first) && (r_hcount <= c_hsync_last);
    assign hblank     = (r_hcount < c_hblank_end) ||
                        (r_hmove_line && (r_hcount < c_hblank_ext));

endmodule

`default_nettype wire

// File: tb/tb_tia_line_scheduler.sv
// ============================================================================
// Module      : tb_tia_line_scheduler
// Description : Directed-then-random bench for tia_line_scheduler against a
//               time/line-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tia_line_scheduler;

    logic       clk = 1'b0;
    logic       resphi0 = 1'b1;
    logic       wsync = 1'b0;
    logic       rsyn = 1'b0;
    logic       hmove = 1'b0;
    logic       phi_theta;
    logic       rdy;
    logic [7:0] hcount;
    logic       line_start;
    logic       hsync;
    logic       hblank;

    tia_line_scheduler u_dut (
        .clk        (clk),
        .resphi0    (resphi0),
        .wsync      (wsync),
        .rsyn       (rsyn),
        .hmove      (hmove),
        .phi_theta  (phi_theta),
        .rdy        (rdy),
        .hcount     (hcount),
        .line_start (line_start),
        .hsync      (hsync),
        .hblank     (hblank)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: absolute clocks since reset, start time of the current
    // line, a running line index, the line that is halted and the set of
    // lines that get the extended blank.
    int m_t;
    int m_origin;
    int m_line;
    int m_halt_line;
    bit m_ext[int];

    function automatic int m_hc();
        return m_t - m_origin;
    endfunction

    task automatic model_step(input bit r, input bit ws, input bit rs, input bit hm);
        int  hc;
        bit  phi;
        bit  wrap;
        if (r) begin
            m_t = 0; m_origin = 0; m_line = 0; m_halt_line = -1;
            m_ext.delete();
        end else begin
            hc   = m_hc();
            phi  = ((m_t % 3) == 2);
            wrap = (hc == 227) || (rs && !phi);
            if (hm && phi) m_ext[wrap ? m_line + 2 : m_line + 1] = 1'b1;
            if (ws && phi && !wrap) m_halt_line = m_line;
            m_t++;
            if (wrap) begin
                m_line++;
                m_origin = m_t;
            end
        end
    endtask

    task automatic check_outputs();
        int hc;
        hc = m_hc();
        chk("hcount",     32'(hcount),     32'(hc));
        chk("phi_theta",  32'(phi_theta),  32'((m_t % 3) == 2));
        chk("rdy",        32'(rdy),        32'(m_halt_line != m_line));
        chk("line_start", 32'(line_start), 32'(hc == 0));
        chk("hsync",      32'(hsync),      32'(hc >= 16 && hc <= 31));
        chk("hblank",     32'(hblank),     32'(hc < 68 || (m_ext.exists(m_line) && hc < 76)));
    endtask

    // One clock: check at the falling edge, choose strobes for the mode,
    // then advance the model with what the DUT sees on the rising edge.
    task automatic cycle(input int mode);
        int hc;
        @(negedge clk);
        check_outputs();
        hc = m_hc();
        resphi0 = 1'b0; wsync = 1'b0; rsyn = 1'b0; hmove = 1'b0;
        case (mode)
            1: begin
                wsync = (hc == 50) || (hc == 51) || (hc == 100);
                hmove = (hc == 80);
            end
            2: wsync = (hc == 51) || (hc == 227);
            3: begin
                wsync = (hc == 50);
                rsyn  = (hc == 100) || (hc == 101);
            end
            4: begin
                wsync   = (hc == 50);
                resphi0 = (hc == 150);
            end
            5: begin
                wsync   = ($urandom_range(0, 15) == 0);
                rsyn    = ($urandom_range(0, 63) == 0);
                hmove   = ($urandom_range(0, 31) == 0);
                resphi0 = ($urandom_range(0, 999) == 0);
            end
            default: ;
        endcase
        @(posedge clk);
        model_step(resphi0, wsync, rsyn, hmove);
    endtask

    initial begin
        resphi0 = 1'b1;
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resphi0 = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        // Re-enter reset so the first checked state is the reset state.
        @(negedge clk);
        resphi0 = 1'b1;
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_hcount",     32'(hcount),     32'd0);
        chk("reset_line_start", 32'(line_start), 32'd1);
        chk("reset_phi",        32'(phi_theta),  32'd0);
        chk("reset_rdy",        32'(rdy),        32'd1);
        chk("reset_hblank",     32'(hblank),     32'd1);
        chk("reset_hsync",      32'(hsync),      32'd0);
        resphi0 = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (456)  cycle(0);
        for (int m = 1; m <= 4; m++) begin
            repeat (456) cycle(m);
        end
        repeat (4000) cycle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
